// File: rtl/avalon_master_multichannel_energy_if.sv
// Avalon-MM bus bundle between the energy master and the system interconnect.
interface avalon_master_multichannel_energy_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
) ();
    logic [ADDRESS_WIDTH-1:0] AVM_AVALONMASTER_ADDRESS;
    logic                     AVM_AVALONMASTER_READ;
    logic                     AVM_AVALONMASTER_WRITE;
    logic                     AVM_AVALONMASTER_WAITREQUEST;
    logic [DATA_WIDTH-1:0]    AVM_AVALONMASTER_READDATA;
    logic [DATA_WIDTH-1:0]    AVM_AVALONMASTER_WRITEDATA;

    modport master (
        output AVM_AVALONMASTER_ADDRESS, AVM_AVALONMASTER_READ, AVM_AVALONMASTER_WRITE,
               AVM_AVALONMASTER_WRITEDATA,
        input  AVM_AVALONMASTER_WAITREQUEST, AVM_AVALONMASTER_READDATA
    );
    modport slave (
        input  AVM_AVALONMASTER_ADDRESS, AVM_AVALONMASTER_READ, AVM_AVALONMASTER_WRITE,
               AVM_AVALONMASTER_WRITEDATA,
        output AVM_AVALONMASTER_WAITREQUEST, AVM_AVALONMASTER_READDATA
    );
endinterface

// File: rtl/avalon_master_multichannel_energy.sv
// Avalon-MM master scanning NUM_CHANNELS block-interleaved sample streams and
// writing one per-channel statistic (abs sum, peak magnitude or signed sum) per block.
module avalon_master_multichannel_energy #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int NUM_CHANNELS  = 2,
    parameter int ACC_WIDTH     = 64,
    parameter int SIZE_WIDTH    = 19,
    parameter int NUM_WIDTH     = 11
) (
    input  logic                                    CSI_CLOCK_CLK,
    input  logic                                    CSI_CLOCK_RESET,
    input  logic                                    START,
    input  logic [1:0]                              MODE,
    input  logic [NUM_WIDTH-1:0]                    NUM,
    input  logic [SIZE_WIDTH-1:0]                   SIZE,
    input  logic [NUM_CHANNELS*ADDRESS_WIDTH-1:0]   CH_BASE,
    input  logic [ADDRESS_WIDTH-1:0]                WADDR,
    output logic                                    BUSY,
    output logic                                    INIT_START,
    output logic                                    DONE,
    avalon_master_multichannel_energy_if.master     avm
);
    localparam int W   = ACC_WIDTH / DATA_WIDTH;
    localparam int WW  = (W > 1) ? $clog2(W) : 1;
    localparam int CHW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [ADDRESS_WIDTH-1:0] STEP     = ADDRESS_WIDTH'(DATA_WIDTH / 8);
    localparam logic [ADDRESS_WIDTH-1:0] RES_STEP = ADDRESS_WIDTH'(W * DATA_WIDTH / 8);
    localparam logic [WW-1:0]            LAST_W   = WW'(W - 1);
    localparam logic [CHW-1:0]           LAST_CH  = CHW'(NUM_CHANNELS - 1);

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_READ, S_WRITE, S_FIN} state_t;

    state_t                                          state_q, state_d;
    logic [1:0]                                      mode_q, mode_d;
    logic [NUM_WIDTH-1:0]                            num_q, num_d;
    logic [SIZE_WIDTH-1:0]                           size_q, size_d, cnt_q, cnt_d;
    logic [NUM_CHANNELS-1:0][ADDRESS_WIDTH-1:0]      ptr_q, ptr_d;
    logic [ADDRESS_WIDTH-1:0]                        wptr_q, wptr_d;
    logic [CHW-1:0]                                  ch_q, ch_d, ch_nxt;
    logic [WW-1:0]                                   w_q, w_d, w_nxt;
    logic [ACC_WIDTH-1:0]                            acc_q, acc_d, acc_next;
    logic [ADDRESS_WIDTH-1:0]                        address_q, address_d;
    logic [DATA_WIDTH-1:0]                           writedata_q, writedata_d;
    logic                                            read_q, read_d, write_q, write_d;
    logic                                            busy_q, busy_d, init_start_q, init_start_d;
    logic                                            done_q, done_d;

    logic                                            rd_acc, wr_acc;
    logic [DATA_WIDTH-1:0]                           sample, mag;
    logic [ACC_WIDTH-1:0]                            mag_ext, sext;
    logic [W-1:0][DATA_WIDTH-1:0]                    acc_words;

    assign rd_acc    = read_q & ~avm.AVM_AVALONMASTER_WAITREQUEST;
    assign wr_acc    = write_q & ~avm.AVM_AVALONMASTER_WAITREQUEST;
    assign acc_words = acc_q;
    assign ch_nxt    = ch_q + 1'b1;
    assign w_nxt     = w_q + 1'b1;

    // Magnitude is taken unsigned so the most negative sample yields 2^(DATA_WIDTH-1).
    always_comb begin
        sample  = avm.AVM_AVALONMASTER_READDATA;
        mag     = sample[DATA_WIDTH-1] ? (~sample + 1'b1) : sample;
        mag_ext = {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, mag};
        sext    = {{(ACC_WIDTH-DATA_WIDTH){sample[DATA_WIDTH-1]}}, sample};
        case (mode_q)
            2'd1:    acc_next = (mag_ext > acc_q) ? mag_ext : acc_q;
            2'd2:    acc_next = acc_q + sext;
            default: acc_next = acc_q + mag_ext;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        num_d        = num_q;
        size_d       = size_q;
        cnt_d        = cnt_q;
        ptr_d        = ptr_q;
        wptr_d       = wptr_q;
        ch_d         = ch_q;
        w_d          = w_q;
        acc_d        = acc_q;
        address_d    = address_q;
        writedata_d  = writedata_q;
        read_d       = read_q;
        write_d      = write_q;
        busy_d       = busy_q;
        init_start_d = 1'b0;
        done_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d      = S_INIT;
                    busy_d       = 1'b1;
                    init_start_d = 1'b1;
                end
            end
            S_INIT: begin
                mode_d = (MODE == 2'd3) ? 2'd0 : MODE;
                num_d  = NUM;
                size_d = SIZE;
                wptr_d = WADDR;
                ptr_d  = CH_BASE;
                ch_d   = '0;
                w_d    = '0;
                cnt_d  = '0;
                acc_d  = '0;
                if (NUM == '0 || SIZE == '0) begin
                    state_d = S_FIN;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d   = S_READ;
                    read_d    = 1'b1;
                    address_d = CH_BASE[ADDRESS_WIDTH-1:0];
                end
            end
            S_READ: begin
                if (rd_acc) begin
                    ptr_d[ch_q] = ptr_q[ch_q] + STEP;
                    acc_d       = acc_next;
                    if (cnt_q == size_q - 1'b1) begin
                        state_d     = S_WRITE;
                        cnt_d       = '0;
                        w_d         = '0;
                        read_d      = 1'b0;
                        write_d     = 1'b1;
                        address_d   = wptr_q;
                        writedata_d = acc_next[DATA_WIDTH-1:0];
                    end else begin
                        cnt_d     = cnt_q + 1'b1;
                        address_d = ptr_q[ch_q] + STEP;
                    end
                end
            end
            S_WRITE: begin
                if (wr_acc) begin
                    if (w_q != LAST_W) begin
                        w_d         = w_nxt;
                        address_d   = address_q + STEP;
                        writedata_d = acc_words[w_nxt];
                    end else begin
                        write_d     = 1'b0;
                        writedata_d = '0;
                        w_d         = '0;
                        acc_d       = '0;
                        wptr_d      = wptr_q + RES_STEP;
                        if (ch_q != LAST_CH) begin
                            ch_d      = ch_nxt;
                            state_d   = S_READ;
                            read_d    = 1'b1;
                            address_d = ptr_q[ch_nxt];
                        end else begin
                            ch_d  = '0;
                            num_d = num_q - 1'b1;
                            if (num_q != NUM_WIDTH'(1)) begin
                                state_d   = S_READ;
                                read_d    = 1'b1;
                                address_d = ptr_q[0];
                            end else begin
                                state_d   = S_FIN;
                                busy_d    = 1'b0;
                                done_d    = 1'b1;
                                address_d = '0;
                            end
                        end
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CSI_CLOCK_CLK) begin
        if (CSI_CLOCK_RESET) begin
            state_q      <= S_IDLE;
            mode_q       <= '0;
            num_q        <= '0;
            size_q       <= '0;
            cnt_q        <= '0;
            ptr_q        <= '0;
            wptr_q       <= '0;
            ch_q         <= '0;
            w_q          <= '0;
            acc_q        <= '0;
            address_q    <= '0;
            writedata_q  <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            busy_q       <= 1'b0;
            init_start_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            num_q        <= num_d;
            size_q       <= size_d;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            wptr_q       <= wptr_d;
            ch_q         <= ch_d;
            w_q          <= w_d;
            acc_q        <= acc_d;
            address_q    <= address_d;
            writedata_q  <= writedata_d;
            read_q       <= read_d;
            write_q      <= write_d;
            busy_q       <= busy_d;
            init_start_q <= init_start_d;
            done_q       <= done_d;
        end
    end

    assign avm.AVM_AVALONMASTER_ADDRESS   = address_q;
    assign avm.AVM_AVALONMASTER_READ      = read_q;
    assign avm.AVM_AVALONMASTER_WRITE     = write_q;
    assign avm.AVM_AVALONMASTER_WRITEDATA = writedata_q;
    assign BUSY       = busy_q;
    assign INIT_START = init_start_q;
    assign DONE       = done_q;
endmodule

// File: tb/tb_avalon_master_multichannel_energy.sv
// Bench for the multichannel energy master: random memory/waits, job-level reference model.
module tb_avalon_master_multichannel_energy;
    localparam int NCH = 3;

    logic              clk, rst, start;
    logic [1:0]        mode;
    logic [10:0]       num;
    logic [18:0]       size;
    logic [NCH*32-1:0] ch_base;
    logic [31:0]       waddr;
    logic              busy, init_start, done;

    int checks = 0;
    int errors = 0;

    avalon_master_multichannel_energy_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) bus ();

    avalon_master_multichannel_energy #(
        .DATA_WIDTH(32), .ADDRESS_WIDTH(32), .NUM_CHANNELS(NCH),
        .ACC_WIDTH(64), .SIZE_WIDTH(19), .NUM_WIDTH(11)
    ) dut (
        .CSI_CLOCK_CLK(clk), .CSI_CLOCK_RESET(rst), .START(start), .MODE(mode),
        .NUM(num), .SIZE(size), .CH_BASE(ch_base), .WADDR(waddr),
        .BUSY(busy), .INIT_START(init_start), .DONE(done), .avm(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory: explicit entries, else a fill value, else an address hash
    logic [31:0] mem [logic [31:0]];
    logic [31:0] salt;
    logic        fill_en;
    logic [31:0] fill_val;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        if (fill_en) return fill_val;
        return (a * 32'h9E3779B1) ^ salt;
    endfunction

    // job configuration and logs
    logic [1:0]  j_mode;
    int          j_num, j_size;
    logic [31:0] j_base [NCH];
    logic [31:0] j_waddr;
    int          wait_pct;
    int          wait_cyc;
    logic [31:0] rd_q[$], wr_a_q[$], wr_d_q[$];
    logic [31:0] exp_rd[$], exp_wa[$], exp_wd[$];

    logic        pend;
    logic [31:0] p_addr, p_wd;
    logic        p_rd, p_wr;

    // slave responder and bus monitor
    always @(negedge clk) begin
        logic wr;
        if (rst) pend = 1'b0;
        if (bus.AVM_AVALONMASTER_READ && bus.AVM_AVALONMASTER_WRITE) begin
            errors++;
            $display("FAIL rd_wr_exclusive: READ and WRITE both high at %0t", $time);
        end
        if (pend) begin
            checks++;
            if (bus.AVM_AVALONMASTER_ADDRESS !== p_addr || bus.AVM_AVALONMASTER_READ !== p_rd ||
                bus.AVM_AVALONMASTER_WRITE !== p_wr || (p_wr && bus.AVM_AVALONMASTER_WRITEDATA !== p_wd)) begin
                errors++;
                $display("FAIL stable_during_wait: addr %h rd %b wr %b wd %h, required addr %h rd %b wr %b wd %h",
                         bus.AVM_AVALONMASTER_ADDRESS, bus.AVM_AVALONMASTER_READ, bus.AVM_AVALONMASTER_WRITE,
                         bus.AVM_AVALONMASTER_WRITEDATA, p_addr, p_rd, p_wr, p_wd);
            end
        end
        wr = (wait_pct > 0) && ($urandom_range(99) < wait_pct);
        bus.AVM_AVALONMASTER_WAITREQUEST = wr;
        bus.AVM_AVALONMASTER_READDATA = bus.AVM_AVALONMASTER_READ ? mem_rd(bus.AVM_AVALONMASTER_ADDRESS) : 32'h0;
        pend = 1'b0;
        if (!rst && (bus.AVM_AVALONMASTER_READ || bus.AVM_AVALONMASTER_WRITE)) begin
            if (wr) begin
                wait_cyc++;
                pend   = 1'b1;
                p_addr = bus.AVM_AVALONMASTER_ADDRESS;
                p_wd   = bus.AVM_AVALONMASTER_WRITEDATA;
                p_rd   = bus.AVM_AVALONMASTER_READ;
                p_wr   = bus.AVM_AVALONMASTER_WRITE;
            end else if (bus.AVM_AVALONMASTER_READ) begin
                rd_q.push_back(bus.AVM_AVALONMASTER_ADDRESS);
            end else begin
                wr_a_q.push_back(bus.AVM_AVALONMASTER_ADDRESS);
                wr_d_q.push_back(bus.AVM_AVALONMASTER_WRITEDATA);
            end
        end
    end

    // Reference model: walk blocks and channels with plain integer statistics.
    function automatic void build_model();
        longint acc, sx, m;
        logic [63:0] u;
        logic [31:0] a;
        exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
        for (int b = 0; b < j_num; b++) begin
            for (int c = 0; c < NCH; c++) begin
                acc = 0;
                for (int s = 0; s < j_size; s++) begin
                    a = j_base[c] + 32'(4 * (b * j_size + s));
                    exp_rd.push_back(a);
                    sx = longint'($signed(mem_rd(a)));
                    m  = (sx < 0) ? -sx : sx;
                    if (j_mode == 2'd1) acc = (m > acc) ? m : acc;
                    else if (j_mode == 2'd2) acc = acc + sx;
                    else acc = acc + m;
                end
                u = acc;
                a = j_waddr + 32'(8 * (b * NCH + c));
                exp_wa.push_back(a);     exp_wd.push_back(u[31:0]);
                exp_wa.push_back(a + 4); exp_wd.push_back(u[63:32]);
            end
        end
    endfunction

    function automatic string rd_mismatch();
        if (rd_q.size() != exp_rd.size())
            return $sformatf("count %0d, required %0d", rd_q.size(), exp_rd.size());
        foreach (rd_q[i])
            if (rd_q[i] !== exp_rd[i]) return $sformatf("#%0d addr %h, required %h", i, rd_q[i], exp_rd[i]);
        return "";
    endfunction

    function automatic string wr_mismatch();
        if (wr_a_q.size() != exp_wa.size())
            return $sformatf("count %0d, required %0d", wr_a_q.size(), exp_wa.size());
        foreach (wr_a_q[i])
            if (wr_a_q[i] !== exp_wa[i] || wr_d_q[i] !== exp_wd[i])
                return $sformatf("#%0d %h=%h, required %h=%h", i, wr_a_q[i], wr_d_q[i], exp_wa[i], exp_wd[i]);
        return "";
    endfunction

    task automatic apply_cfg();
        mode = j_mode; num = 11'(j_num); size = 19'(j_size); waddr = j_waddr;
        for (int c = 0; c < NCH; c++) ch_base[c*32 +: 32] = j_base[c];
        rd_q.delete(); wr_a_q.delete(); wr_d_q.delete(); wait_cyc = 0;
    endtask

    // Runs one job; done_off is the cycle of DONE counted from the START edge.
    task automatic run_job(input int wp, output int done_off);
        int bound;
        bound = 40 + 4 * j_num * NCH * (j_size + 2);
        @(negedge clk);
        apply_cfg();
        wait_pct = wp;
        start = 1'b1;
        @(posedge clk);
        done_off = -1;
        for (int c = 1; c <= bound && done_off < 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0;
                checks++;
                if (init_start !== 1'b1 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL init_pulse: init_start %b busy %b, required 1 1", init_start, busy);
                end
            end
            if (c == 2) begin
                mode = 2'($urandom); num = 11'($urandom); size = 19'($urandom); waddr = $urandom;
                for (int k = 0; k < NCH; k++) ch_base[k*32 +: 32] = $urandom;
            end
            if (done === 1'b1) begin
                done_off = c;
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_in_fin: busy %b, required 0", busy);
                end
            end
        end
        wait_pct = 0;
        checks++;
        if (done_off < 0) begin
            errors++;
            $display("FAIL job_timeout: no DONE within %0d cycles", bound);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; wait_pct = 0; fill_en = 1'b0; salt = $urandom;
        j_mode = 0; j_num = 1; j_size = 1; j_waddr = 0;
        for (int c = 0; c < NCH; c++) j_base[c] = 0;
        apply_cfg();
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, init_start, bus.AVM_AVALONMASTER_READ, bus.AVM_AVALONMASTER_WRITE} !== 5'b0 ||
            bus.AVM_AVALONMASTER_ADDRESS !== 32'h0 || bus.AVM_AVALONMASTER_WRITEDATA !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: busy %b done %b init %b rd %b wr %b addr %h wd %h, required all 0",
                     busy, done, init_start, bus.AVM_AVALONMASTER_READ, bus.AVM_AVALONMASTER_WRITE,
                     bus.AVM_AVALONMASTER_ADDRESS, bus.AVM_AVALONMASTER_WRITEDATA);
        end
        start = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy %b, required 0", busy);
        end
    endtask

    task automatic test_modes();
        logic [31:0] want [4][4];
        int off;
        string msg;
        mem.delete(); fill_en = 1'b0; salt = $urandom;
        j_base[0] = 32'h1000; j_base[1] = 32'h2000; j_base[2] = 32'h3000; j_waddr = 32'h8000;
        j_num = 1; j_size = 4;
        mem[32'h1000] = 32'd1; mem[32'h1004] = 32'hFFFFFFFE; mem[32'h1008] = 32'd3; mem[32'h100C] = 32'hFFFFFFFC;
        mem[32'h2000] = 32'h80000000; mem[32'h2004] = 0; mem[32'h2008] = 0; mem[32'h200C] = 0;
        want[0] = '{32'd10, 32'd0, 32'h80000000, 32'd0};
        want[1] = '{32'd4, 32'd0, 32'h80000000, 32'd0};
        want[2] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
        want[3] = want[0];
        for (int m = 0; m < 4; m++) begin
            j_mode = 2'(m);
            run_job(0, off);
            build_model();
            checks++;
            if (off != 2 + 12 + 6) begin
                errors++;
                $display("FAIL mode%0d_done_cycle: DONE at t+%0d, required t+20", m, off);
            end
            checks++; msg = rd_mismatch();
            if (msg != "") begin errors++; $display("FAIL mode%0d_reads: %s", m, msg); end
            checks++; msg = wr_mismatch();
            if (msg != "") begin errors++; $display("FAIL mode%0d_writes: %s", m, msg); end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wr_d_q.size() < 4 || wr_d_q[i] !== want[m][i]) begin
                    errors++;
                    $display("FAIL mode%0d_word%0d: got %h, required %h", m, i,
                             (wr_d_q.size() > i) ? wr_d_q[i] : 32'hx, want[m][i]);
                end
            end
        end
    endtask

    task automatic test_random_waits();
        int off;
        string msg;
        for (int it = 0; it < 6; it++) begin
            mem.delete(); fill_en = 1'b0; salt = $urandom;
            j_mode = (it < 3) ? 2'(it) : 2'($urandom_range(3));
            j_num  = (it == 0) ? 3 : $urandom_range(1, 3);
            j_size = (it == 0) ? 2 : $urandom_range(1, 6);
            for (int c = 0; c < NCH; c++) j_base[c] = $urandom & 32'hFFFFFFFC;
            j_waddr = $urandom & 32'hFFFFFFFC;
            run_job(50, off);
            build_model();
            checks++;
            if (off != 2 + exp_rd.size() + exp_wa.size() + wait_cyc) begin
                errors++;
                $display("FAIL rand%0d_done_cycle: t+%0d, required t+%0d", it, off,
                         2 + exp_rd.size() + exp_wa.size() + wait_cyc);
            end
            checks++; msg = rd_mismatch();
            if (msg != "") begin errors++; $display("FAIL rand%0d_reads: %s", it, msg); end
            checks++; msg = wr_mismatch();
            if (msg != "") begin errors++; $display("FAIL rand%0d_writes: %s", it, msg); end
        end
    endtask

    task automatic test_degenerate();
        int off;
        for (int it = 0; it < 2; it++) begin
            j_mode = 0;
            j_num  = (it == 0) ? 0 : 3;
            j_size = (it == 0) ? 5 : 0;
            run_job(0, off);
            checks++;
            if (off != 2) begin
                errors++;
                $display("FAIL degen%0d_done_cycle: t+%0d, required t+2", it, off);
            end
            checks++;
            if (rd_q.size() != 0 || wr_a_q.size() != 0) begin
                errors++;
                $display("FAIL degen%0d_no_traffic: %0d reads %0d writes, required 0 0", it, rd_q.size(), wr_a_q.size());
            end
        end
    endtask

    task automatic test_reset_mid_job();
        int off;
        logic hit, saw;
        string msg;
        mem.delete(); fill_en = 1'b0; salt = $urandom;
        j_mode = 2'd2; j_num = 2; j_size = 4;
        for (int c = 0; c < NCH; c++) j_base[c] = $urandom & 32'hFFFFFFFC;
        j_waddr = $urandom & 32'hFFFFFFFC;
        @(negedge clk);
        apply_cfg();
        wait_pct = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 50 && !hit; c++) begin
            @(negedge clk);
            if (rd_q.size() >= 2 && bus.AVM_AVALONMASTER_READ) hit = 1'b1;
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL midjob_reach_read3: third read not reached, required reached"); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, init_start, bus.AVM_AVALONMASTER_READ, bus.AVM_AVALONMASTER_WRITE} !== 5'b0 ||
            bus.AVM_AVALONMASTER_ADDRESS !== 32'h0) begin
            errors++;
            $display("FAIL midjob_reset_outputs: busy %b done %b rd %b wr %b addr %h, required all 0",
                     busy, done, bus.AVM_AVALONMASTER_READ, bus.AVM_AVALONMASTER_WRITE, bus.AVM_AVALONMASTER_ADDRESS);
        end
        rst = 1'b0;
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) saw = 1'b1;
        end
        checks++;
        if (saw) begin errors++; $display("FAIL midjob_no_done: DONE/BUSY seen after reset, required none"); end
        run_job(0, off);
        build_model();
        checks++; msg = rd_mismatch();
        if (msg != "") begin errors++; $display("FAIL rerun_reads: %s", msg); end
        checks++; msg = wr_mismatch();
        if (msg != "") begin errors++; $display("FAIL rerun_writes: %s", msg); end
    endtask

    task automatic test_large();
        int off;
        logic [63:0] want [3];
        logic [31:0] fv [3];
        logic [1:0]  fm [3];
        fv[0] = 32'h80000000; fm[0] = 2'd0; want[0] = 64'd1500 << 31;
        fv[1] = 32'hFFFFFFFF; fm[1] = 2'd0; want[1] = 64'd1500;
        fv[2] = 32'hFFFFFFFF; fm[2] = 2'd2; want[2] = -64'sd1500;
        mem.delete();
        for (int it = 0; it < 3; it++) begin
            fill_en = 1'b1; fill_val = fv[it];
            j_mode = fm[it]; j_num = 1; j_size = 1500;
            for (int c = 0; c < NCH; c++) j_base[c] = 32'h10000 * (c + 1);
            j_waddr = 32'h40000;
            run_job(0, off);
            checks++;
            if (wr_d_q.size() != 2 * NCH || {wr_d_q[1], wr_d_q[0]} !== want[it] ||
                {wr_d_q[5], wr_d_q[4]} !== want[it]) begin
                errors++;
                $display("FAIL large%0d_acc: got %0d words first %h%h, required %h", it, wr_d_q.size(),
                         (wr_d_q.size() > 1) ? wr_d_q[1] : 32'hx, (wr_d_q.size() > 0) ? wr_d_q[0] : 32'hx, want[it]);
            end
        end
        fill_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] dpat, ipat;
        j_mode = 0; j_num = 0; j_size = 3;
        @(negedge clk);
        apply_cfg();
        start = 1'b1;
        @(posedge clk);
        dpat = '0; ipat = '0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            dpat[c] = done;
            ipat[c] = init_start;
        end
        start = 1'b0;
        checks++;
        if (dpat !== 16'h0124) begin
            errors++;
            $display("FAIL b2b_done_pattern: %h, required 0124", dpat);
        end
        checks++;
        if (ipat !== 16'h0092) begin
            errors++;
            $display("FAIL b2b_init_pattern: %h, required 0092", ipat);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stops: busy %b done %b, required 0 0", busy, done);
        end
    endtask

    initial begin
        pend = 1'b0;
        test_reset();
        test_modes();
        test_random_waits();
        test_degenerate();
        test_reset_mid_job();
        test_large();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
